hazard_sched: RTL and testbench

HAZARD_SCHED -- requirements
Module: hazard_sched

---
 rtl/hazard_sched.sv | 126 ++++++++++++
 tb/tb_hazard_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// hazard_sched -- in-order pipeline hazard scheduler.
//
// Keeps a 32-entry scoreboard of 2-bit pending-write counts and derives the
// PC / pipeline-register write enables and bubble-insert controls from it.
// Priority: mem_busy (freeze) > branch flush > RAW/WAW hazard stall > normal.
//
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   valid_ifid, rs1/rs2_ifid, rs*_used instruction in ID and its sources
//   rd_ifid, rdwren_ifid               destination of the instruction in ID
//   pcsel_exmem, is_br/is_uncbr_exmem  redirect resolved in EX/MEM
//   mem_busy                           LSU stall, freezes the whole pipe
//   pc_wren, wren_ifid, pipe_en        write enables
//   clear_ifid/idex/exmem              synchronous bubble inserts
//
// Optional: define HAZARD_SCHED_PERF_EN to add the saturating 16-bit
// stall_cycles and flush_count counters as outputs.
module hazard_sched (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        valid_ifid,
    input  logic [4:0]  rs1_ifid,
    input  logic [4:0]  rs2_ifid,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  rd_ifid,
    input  logic        rdwren_ifid,
    input  logic        pcsel_exmem,
    input  logic        is_br_exmem,
    input  logic        is_uncbr_exmem,
    input  logic        mem_busy,
    output logic        pc_wren,
    output logic        wren_ifid,
    output logic        clear_ifid,
    output logic        clear_idex,
    output logic        clear_exmem,
    output logic        pipe_en
`ifdef HAZARD_SCHED_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    // One pending count per architectural register; 3 covers EX, MEM, WB.
    logic [31:0][1:0] scb;

    logic flush, hazard, issue;
    logic rs1_busy, rs2_busy, rd_busy;

    assign flush    = pcsel_exmem & (is_br_exmem | is_uncbr_exmem);
    assign rs1_busy = rs1_used & (rs1_ifid != 5'd0) & (scb[rs1_ifid] != 2'd0);
    assign rs2_busy = rs2_used & (rs2_ifid != 5'd0) & (scb[rs2_ifid] != 2'd0);
    // A pending write to rd blocks reissue so one register never has two
    // writers in flight (the count would otherwise be overwritten early).
    assign rd_busy  = rdwren_ifid & (rd_ifid != 5'd0) & (scb[rd_ifid] != 2'd0);
    assign hazard   = valid_ifid & (rs1_busy | rs2_busy | rd_busy);
    assign issue    = valid_ifid & rdwren_ifid & (rd_ifid != 5'd0)
                    & ~hazard & ~flush & ~mem_busy;

    always_comb begin
        pc_wren     = 1'b1;
        wren_ifid   = 1'b1;
        pipe_en     = 1'b1;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        clear_exmem = 1'b0;
        if (i_rst) begin
            pc_wren     = 1'b0;
            wren_ifid   = 1'b0;
            pipe_en     = 1'b0;
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
        end else if (mem_busy) begin
            // Full freeze; a concurrent flush stays on the frozen EX/MEM
            // inputs and is applied once mem_busy drops.
            pc_wren   = 1'b0;
            wren_ifid = 1'b0;
            pipe_en   = 1'b0;
        end else if (flush) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
        end else if (hazard) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            pc_wren    = 1'b0;
            wren_ifid  = 1'b0;
            clear_idex = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scb <= '0;
        end else if (!mem_busy) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 0)
                    scb[i] <= 2'd0;
                else if (flush && scb[i] == 2'd3)
                    // Count 3 belongs to the instruction leaving ID/EX, which
                    // the flush squashes, so its write never happens.
                    scb[i] <= 2'd0;
                else if (scb[i] != 2'd0)
                    scb[i] <= scb[i] - 2'd1;
            end
            if (issue)
                scb[rd_ifid] <= 2'd3;
        end
    end

`ifdef HAZARD_SCHED_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (hazard && !flush && !mem_busy && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush && !mem_busy && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched. The reference model tracks in-flight
// register writers as a queue of {rd, cycles_left} records.
module tb_hazard_sched;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       valid_ifid, rs1_used, rs2_used, rdwren_ifid;
    logic [4:0] rs1_ifid, rs2_ifid, rd_ifid;
    logic       pcsel_exmem, is_br_exmem, is_uncbr_exmem, mem_busy;
    logic       pc_wren, wren_ifid, clear_ifid, clear_idex, clear_exmem, pipe_en;
`ifdef HAZARD_SCHED_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    hazard_sched dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .valid_ifid(valid_ifid), .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_ifid(rd_ifid), .rdwren_ifid(rdwren_ifid),
        .pcsel_exmem(pcsel_exmem), .is_br_exmem(is_br_exmem),
        .is_uncbr_exmem(is_uncbr_exmem), .mem_busy(mem_busy),
        .pc_wren(pc_wren), .wren_ifid(wren_ifid), .clear_ifid(clear_ifid),
        .clear_idex(clear_idex), .clear_exmem(clear_exmem), .pipe_en(pipe_en)
`ifdef HAZARD_SCHED_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // {pc_wren, wren_ifid, clear_ifid, clear_idex, clear_exmem, pipe_en}
    logic [5:0] ov;
    assign ov = {pc_wren, wren_ifid, clear_ifid, clear_idex, clear_exmem, pipe_en};
    localparam logic [5:0] NORM  = 6'b110001;
    localparam logic [5:0] STALL = 6'b000101;
    localparam logic [5:0] FLUSH = 6'b111111;
    localparam logic [5:0] FRZ   = 6'b000000;
    localparam logic [5:0] RSTV  = 6'b001110;

    int checks = 0;
    int errors = 0;

    typedef struct { int rd; int left; } fl_t;
    fl_t q[$];

    function automatic int pend(int r);
        foreach (q[k]) if (q[k].rd == r) return q[k].left;
        return 0;
    endfunction

    function automatic bit m_flush();
        return pcsel_exmem && (is_br_exmem || is_uncbr_exmem);
    endfunction

    function automatic bit m_hazard();
        return valid_ifid &&
            ((rs1_used && rs1_ifid != 0 && pend(int'(rs1_ifid)) != 0) ||
             (rs2_used && rs2_ifid != 0 && pend(int'(rs2_ifid)) != 0) ||
             (rdwren_ifid && rd_ifid != 0 && pend(int'(rd_ifid)) != 0));
    endfunction

    function automatic logic [5:0] exp_out();
        if (i_rst) return RSTV;
        if (mem_busy) return FRZ;
        if (m_flush()) return FLUSH;
        if (m_hazard()) return STALL;
        return NORM;
    endfunction

    function automatic logic [63:0] exp_scb();
        logic [63:0] v = '0;
        int p;
        if (i_rst) return v;
        for (int r = 0; r < 32; r++) begin
            p = pend(r);
            v[r*2 +: 2] = 2'(p);
        end
        return v;
    endfunction

    task automatic model_step();
        fl_t nq[$];
        fl_t e;
        bit fl, iss;
        if (i_rst) begin
            q.delete();
        end else if (!mem_busy) begin
            fl  = m_flush();
            iss = valid_ifid && rdwren_ifid && rd_ifid != 0 && !m_hazard() && !fl;
            foreach (q[k]) begin
                if (fl && q[k].left == 3) continue;   // squashed in ID/EX
                if (q[k].left > 1) begin
                    e.rd = q[k].rd; e.left = q[k].left - 1; nq.push_back(e);
                end
            end
            q = nq;
            if (iss) begin
                e.rd = int'(rd_ifid); e.left = 3; q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        valid_ifid = 0; rs1_ifid = 0; rs2_ifid = 0; rs1_used = 0; rs2_used = 0;
        rd_ifid = 0; rdwren_ifid = 0; pcsel_exmem = 0; is_br_exmem = 0;
        is_uncbr_exmem = 0; mem_busy = 0;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                             input logic u2, input logic [4:0] d, input logic w);
        valid_ifid = 1; rs1_ifid = r1; rs1_used = u1; rs2_ifid = r2; rs2_used = u2;
        rd_ifid = d; rdwren_ifid = w;
    endtask

    task automatic drain();
        set_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        i_rst = 1; set_idle();
        #2;
        checks++; if (ov !== RSTV) begin errors++; $display("FAIL reset_out: got %b expected %b", ov, RSTV); end
        tick();
        checks++; if (dut.scb !== 64'd0) begin errors++; $display("FAIL reset_scb: got %h expected 0", dut.scb); end
        i_rst = 0;
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL reset_first: got %b expected %b", ov, NORM); end
        tick();
    endtask

    task automatic test_raw_stall();
        set_instr(5'd0, 0, 5'd0, 0, 5'd5, 1);
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL raw_issue: got %b expected %b", ov, NORM); end
        tick();
        set_instr(5'd5, 1, 5'd0, 0, 5'd0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ov !== STALL) begin errors++; $display("FAIL raw_stall%0d: got %b expected %b", c, ov, STALL); end
            tick();
        end
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL raw_release: got %b expected %b", ov, NORM); end
        tick();
        drain();
    endtask

    task automatic test_x0();
        set_instr(5'd0, 0, 5'd0, 0, 5'd9, 1);
        #1;
        tick();
        set_instr(5'd0, 1, 5'd0, 1, 5'd0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ov !== NORM) begin errors++; $display("FAIL x0_nostall%0d: got %b expected %b", c, ov, NORM); end
            tick();
            checks++; if (dut.scb[0] !== 2'd0) begin errors++; $display("FAIL x0_scb%0d: got %0d expected 0", c, dut.scb[0]); end
        end
        drain();
    endtask

    task automatic test_flush();
        set_instr(5'd0, 0, 5'd0, 0, 5'd7, 1);
        #1;
        tick();
        set_instr(5'd0, 0, 5'd7, 1, 5'd0, 0);
        pcsel_exmem = 1; is_uncbr_exmem = 1;
        #1;
        checks++; if (ov !== FLUSH) begin errors++; $display("FAIL flush_out: got %b expected %b", ov, FLUSH); end
        checks++; if (dut.scb[7] !== 2'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", dut.scb[7]); end
        tick();
        checks++; if (dut.scb[7] !== 2'd0) begin errors++; $display("FAIL flush_squash: got %0d expected 0", dut.scb[7]); end
        set_idle();
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL flush_after: got %b expected %b", ov, NORM); end
        drain();
    endtask

    task automatic test_mem_busy();
        set_instr(5'd0, 0, 5'd0, 0, 5'd9, 1);
        #1;
        tick();
        set_idle();
        tick();
        mem_busy = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (ov !== FRZ) begin errors++; $display("FAIL busy_out%0d: got %b expected %b", c, ov, FRZ); end
            checks++; if (dut.scb[9] !== 2'd2) begin errors++; $display("FAIL busy_hold%0d: got %0d expected 2", c, dut.scb[9]); end
            tick();
        end
        mem_busy = 0;
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL busy_release: got %b expected %b", ov, NORM); end
        tick();
        checks++; if (dut.scb[9] !== 2'd1) begin errors++; $display("FAIL busy_dec1: got %0d expected 1", dut.scb[9]); end
        tick();
        checks++; if (dut.scb[9] !== 2'd0) begin errors++; $display("FAIL busy_dec0: got %0d expected 0", dut.scb[9]); end
        drain();
    endtask

    task automatic test_busy_flush();
        pcsel_exmem = 1; is_br_exmem = 1; mem_busy = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (ov !== FRZ) begin errors++; $display("FAIL bflush_hold%0d: got %b expected %b", c, ov, FRZ); end
            tick();
        end
        mem_busy = 0;
        #1;
        checks++; if (ov !== FLUSH) begin errors++; $display("FAIL bflush_apply: got %b expected %b", ov, FLUSH); end
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        set_instr(5'd0, 0, 5'd0, 0, 5'd3, 1);
        #1;
        tick();
        set_instr(5'd3, 1, 5'd0, 0, 5'd0, 0);
        #1;
        checks++; if (ov !== STALL) begin errors++; $display("FAIL rmid_stall: got %b expected %b", ov, STALL); end
        i_rst = 1;
        #1;
        checks++; if (ov !== RSTV) begin errors++; $display("FAIL rmid_out: got %b expected %b", ov, RSTV); end
        checks++; if (dut.scb !== 64'd0) begin errors++; $display("FAIL rmid_scb: got %h expected 0", dut.scb); end
        tick();
        i_rst = 0;
        #1;
        checks++; if (ov !== NORM) begin errors++; $display("FAIL rmid_after: got %b expected %b", ov, NORM); end
        tick();
        drain();
    endtask

    task automatic test_random();
        logic [5:0]  eo;
        logic [63:0] es;
        for (int c = 0; c < 2000; c++) begin
            if (i_rst) i_rst = 0;
            else if ($urandom_range(0, 149) == 0) i_rst = 1;
            valid_ifid     = ($urandom_range(0, 3) != 0);
            rs1_ifid       = 5'($urandom_range(0, 7));
            rs2_ifid       = 5'($urandom_range(0, 7));
            rd_ifid        = 5'($urandom_range(0, 7));
            rs1_used       = 1'($urandom_range(0, 1));
            rs2_used       = 1'($urandom_range(0, 1));
            rdwren_ifid    = 1'($urandom_range(0, 1));
            pcsel_exmem    = ($urandom_range(0, 7) == 0);
            is_br_exmem    = 1'($urandom_range(0, 1));
            is_uncbr_exmem = 1'($urandom_range(0, 1));
            mem_busy       = ($urandom_range(0, 5) == 0);
            #1;
            eo = exp_out();
            es = exp_scb();
            checks++; if (ov !== eo) begin errors++; $display("FAIL rand_out@%0d: got %b expected %b", c, ov, eo); end
            checks++; if (dut.scb !== es) begin errors++; $display("FAIL rand_scb@%0d: got %h expected %h", c, dut.scb, es); end
            tick();
        end
        i_rst = 0;
        drain();
    endtask

`ifdef HAZARD_SCHED_PERF_EN
    task automatic test_perf();
        i_rst = 1; set_idle();
        #1;
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
        tick();
        i_rst = 0;
        set_instr(5'd0, 0, 5'd0, 0, 5'd5, 1);
        tick();
        set_instr(5'd5, 1, 5'd0, 0, 5'd0, 0);
        repeat (3) tick();
        set_idle();
        pcsel_exmem = 1; is_br_exmem = 1;
        repeat (2) tick();
        set_idle();
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL perf_stalls: got %0d expected 3", stall_cycles); end
        checks++; if (flush_count !== 16'd2) begin errors++; $display("FAIL perf_flushes: got %0d expected 2", flush_count); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_raw_stall();
        test_x0();
        test_flush();
        test_mem_busy();
        test_busy_flush();
        test_reset_mid();
        test_random();
`ifdef HAZARD_SCHED_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
